// File: rtl/alu_instr_sequencer_if.sv
// Handshake and strobe bundle between the instruction sequencer (master)
// and the shared-bus datapath (slave).
interface alu_instr_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int RIDX_W = 4
);
    localparam int NUM_REGS = 2 ** RIDX_W;

    logic                run;
    logic                mem_ready;
    logic [DATA_W-1:0]   ir_in;
    logic                pc_out;
    logic                mar_enable;
    logic                pc_increment;
    logic                read;
    logic                mdr_enable;
    logic                mdr_out;
    logic                ir_enable;
    logic                y_enable;
    logic                z_enable;
    logic                zlo_out;
    logic                zhi_out;
    logic                lo_enable;
    logic                hi_enable;
    logic [NUM_REGS-1:0] reg_out;
    logic [NUM_REGS-1:0] reg_enable;
    logic [4:0]          op_code;
    logic                busy;
    logic                done;
    logic                illegal;

    modport master (
        input  run, mem_ready, ir_in,
        output pc_out, mar_enable, pc_increment, read, mdr_enable, mdr_out,
               ir_enable, y_enable, z_enable, zlo_out, zhi_out, lo_enable,
               hi_enable, reg_out, reg_enable, op_code, busy, done, illegal
    );

    modport slave (
        output run, mem_ready, ir_in,
        input  pc_out, mar_enable, pc_increment, read, mdr_enable, mdr_out,
               ir_enable, y_enable, z_enable, zlo_out, zhi_out, lo_enable,
               hi_enable, reg_out, reg_enable, op_code, busy, done, illegal
    );
endinterface

// File: rtl/alu_instr_sequencer.sv
// Fetch/execute control sequencer for register and ALU instructions on a
// shared-bus datapath: steps T0..T6 plus an illegal-opcode trap state.
module alu_instr_sequencer #(
    parameter int DATA_W  = 32,
    parameter int RIDX_W  = 4,
    parameter int R0_ZERO = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    alu_instr_sequencer_if.master bus
);
    localparam int NUM_REGS = 2 ** RIDX_W;
    localparam int LOW_W    = DATA_W - 5 - 3 * RIDX_W;
    localparam logic [NUM_REGS-1:0] REG_ONE = NUM_REGS'(1);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_ILL
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          opc_q, opc_d;
    logic [RIDX_W-1:0]   ra_q, ra_d;
    logic [RIDX_W-1:0]   rb_q, rb_d;
    logic [RIDX_W-1:0]   rc_q, rc_d;

    logic [4:0]          opc_ir;
    logic [RIDX_W-1:0]   ra_ir, rb_ir, rc_ir;
    logic                final_step;

    function automatic logic is_muldiv(input logic [4:0] opc);
        return (opc == OP_MUL) || (opc == OP_DIV);
    endfunction

    function automatic logic is_three_op(input logic [4:0] opc);
        return (opc inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
                            OP_SHR, OP_SHRA, OP_SHL}) || is_muldiv(opc);
    endfunction

    function automatic logic is_unary(input logic [4:0] opc);
        return (opc == OP_NEG) || (opc == OP_NOT);
    endfunction

    assign opc_ir = bus.ir_in[DATA_W-1 -: 5];
    assign ra_ir  = bus.ir_in[LOW_W + 2*RIDX_W +: RIDX_W];
    assign rb_ir  = bus.ir_in[LOW_W + RIDX_W +: RIDX_W];
    assign rc_ir  = bus.ir_in[LOW_W +: RIDX_W];

    if (LOW_W > 0) begin : g_low_bits
        logic unused_ir_low;
        assign unused_ir_low = ^bus.ir_in[LOW_W-1:0];
    end

    assign final_step = (state_q == S_T6) || (state_q == S_ILL) ||
                        ((state_q == S_T5) && !is_muldiv(opc_q));

    // Next-state logic; the IR fields are only trusted in T3, after the IR load in T2.
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        case (state_q)
            S_IDLE: if (bus.run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (bus.mem_ready) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                opc_d = opc_ir;
                ra_d  = ra_ir;
                rb_d  = rb_ir;
                rc_d  = rc_ir;
                if (is_three_op(opc_ir))   state_d = S_T4;
                else if (is_unary(opc_ir)) state_d = S_T5;
                else                       state_d = S_ILL;
            end
            S_T4:   state_d = S_T5;
            S_T5:   if (is_muldiv(opc_q)) state_d = S_T6;
            default: ;
        endcase
        if (final_step) state_d = bus.run ? S_T0 : S_IDLE;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            opc_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
        end
    end

    // Strobes decode from the state register and latched fields; each step drives the bus at most once.
    always_comb begin
        bus.pc_out       = 1'b0;
        bus.mar_enable   = 1'b0;
        bus.pc_increment = 1'b0;
        bus.read         = 1'b0;
        bus.mdr_enable   = 1'b0;
        bus.mdr_out      = 1'b0;
        bus.ir_enable    = 1'b0;
        bus.y_enable     = 1'b0;
        bus.z_enable     = 1'b0;
        bus.zlo_out      = 1'b0;
        bus.zhi_out      = 1'b0;
        bus.lo_enable    = 1'b0;
        bus.hi_enable    = 1'b0;
        bus.reg_out      = '0;
        bus.reg_enable   = '0;
        bus.op_code      = '0;
        bus.done         = 1'b0;
        bus.illegal      = 1'b0;
        bus.busy         = (state_q != S_IDLE);
        case (state_q)
            S_T0: begin
                bus.pc_out       = 1'b1;
                bus.mar_enable   = 1'b1;
                bus.pc_increment = 1'b1;
            end
            S_T1: begin
                bus.read       = 1'b1;
                bus.mdr_enable = 1'b1;
            end
            S_T2: begin
                bus.mdr_out   = 1'b1;
                bus.ir_enable = 1'b1;
            end
            S_T3: begin
                if (is_three_op(opc_ir)) begin
                    bus.reg_out  = REG_ONE << rb_ir;
                    bus.y_enable = 1'b1;
                end else if (is_unary(opc_ir)) begin
                    bus.reg_out  = REG_ONE << rb_ir;
                    bus.op_code  = opc_ir;
                    bus.z_enable = 1'b1;
                end
            end
            S_T4: begin
                bus.reg_out  = REG_ONE << rc_q;
                bus.op_code  = opc_q;
                bus.z_enable = 1'b1;
            end
            S_T5: begin
                bus.op_code = opc_q;
                bus.zlo_out = 1'b1;
                if (is_muldiv(opc_q)) begin
                    bus.lo_enable = 1'b1;
                end else begin
                    bus.done = 1'b1;
                    if (!((R0_ZERO != 0) && (ra_q == '0)))
                        bus.reg_enable = REG_ONE << ra_q;
                end
            end
            S_T6: begin
                bus.op_code   = opc_q;
                bus.zhi_out   = 1'b1;
                bus.hi_enable = 1'b1;
                bus.done      = 1'b1;
            end
            S_ILL: begin
                bus.illegal = 1'b1;
                bus.done    = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
